otp_xor: RTL and testbench

OTP_XOR -- requirements
Module: otp_xor

---
 rtl/otp_xor.sv | 141 ++++++++++++++
 tb/tb_otp_xor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_xor.sv
// One-time-pad XOR engine for a block of nibbles held in RAM.
// For every 16-nibble group it requests a fresh 64-bit pad. It then streams
// 16 read addresses, and writes (read data XOR pad nibble) one cycle behind
// each read. The block is finished when the ADDR_W-bit nibble counter wraps.
// ADDR_W must be at least 4 so that a block holds whole 16-nibble groups.
module otp_xor #(
  parameter int ADDR_W = 10
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              istart,
  output logic              ogen_otp,
  input  logic              iotp_ready,
  input  logic [63:0]       iotp,
  output logic [ADDR_W-1:0] ord_addr,
  input  logic [3:0]        irdata,
  output logic [ADDR_W-1:0] owr_addr,
  output logic [3:0]        owdata,
  output logic              owrite_en,
  output logic              obusy,
  output logic              odone
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_XOR  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Pad nibble idx, counted from the most significant nibble:
  // idx 0 -> pad[63:60], idx 15 -> pad[3:0].
  function automatic logic [3:0] pad_nibble(input logic [63:0] pad, input logic [3:0] idx);
    logic [5:0] lsb;
    lsb = {~idx, 2'b00};
    return pad[lsb +: 4];
  endfunction

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;      // address of the next nibble to read
  logic [63:0]       pad_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [3:0]        wnib_q;     // pad nibble that belongs to wr_addr_q
  logic              wr_en_q;
  logic              gen_q;
  logic              busy_q;
  logic              done_q;

  logic [ADDR_W-1:0] cnt_d;
  logic [3:0]        nib_d;

  // Counter increment and the pad nibble for the address being read.
  always_comb begin
    cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    nib_d = pad_nibble(pad_q, rd_addr_q[3:0]);
  end

  // Control FSM together with the read address and the one-cycle write stage.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {ADDR_W{1'b0}};
      pad_q     <= 64'h0;
      rd_addr_q <= {ADDR_W{1'b0}};
      wr_addr_q <= {ADDR_W{1'b0}};
      wnib_q    <= 4'h0;
      wr_en_q   <= 1'b0;
      gen_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Every read issued in XOR is written back on the next cycle,
      // whichever state follows.
      wr_en_q <= (state_q == ST_XOR);
      if (state_q == ST_XOR) begin
        wr_addr_q <= rd_addr_q;
        wnib_q    <= nib_d;
      end

      case (state_q)
        ST_IDLE: begin
          gen_q  <= 1'b0;
          done_q <= 1'b0;
          if (istart) begin
            state_q <= ST_REQ;
            cnt_q   <= {ADDR_W{1'b0}};
            gen_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_REQ: begin
          gen_q   <= 1'b0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (iotp_ready) begin
            pad_q     <= iotp;
            rd_addr_q <= cnt_q;
            cnt_q     <= cnt_d;
            state_q   <= ST_XOR;
          end
        end
        ST_XOR: begin
          if (cnt_q[3:0] != 4'd0) begin
            rd_addr_q <= cnt_q;
            cnt_q     <= cnt_d;
          end else if (cnt_q == {ADDR_W{1'b0}}) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_REQ;
            gen_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          gen_q   <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ogen_otp  = gen_q;
  assign ord_addr  = rd_addr_q;
  assign owr_addr  = wr_addr_q;
  assign owrite_en = wr_en_q;
  assign obusy     = busy_q;
  assign odone     = done_q;
  // The RAM data arrives during the write cycle, so only this XOR is combinational.
  assign owdata    = wr_en_q ? (irdata ^ wnib_q) : 4'h0;

endmodule

// File: tb/tb_otp_xor.sv
// Directed bench for otp_xor: RAM model, pad responder, write monitor.
module tb_otp_xor;
  localparam int AW = 10;
  localparam int N  = 1024;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          ogen_otp, iotp_ready;
  logic [63:0]   iotp;
  logic [AW-1:0] ord_addr, owr_addr;
  logic [3:0]    irdata, owdata;
  logic          owrite_en, obusy, odone;

  logic          resp_ready, inj_ready;
  logic [63:0]   resp_val, inj_val, pad_val;
  int            resp_lat;

  logic [3:0]    in_ram  [N];
  logic [3:0]    out_ram [N];

  int            n_total = 0, n_pass = 0;
  int            cyc = 0, wr_cnt = 0, ogen_cnt = 0, done_cnt = 0, done_cyc = 0;
  int            done_waddr = 0;
  int            wr_log_a[$];
  logic [3:0]    wr_log_d[$];

  assign iotp_ready = resp_ready | inj_ready;
  assign iotp       = inj_ready ? inj_val : resp_val;

  otp_xor #(.ADDR_W(AW)) dut (
    .iclk(clk), .irst(rst), .istart(start), .ogen_otp(ogen_otp),
    .iotp_ready(iotp_ready), .iotp(iotp), .ord_addr(ord_addr), .irdata(irdata),
    .owr_addr(owr_addr), .owdata(owdata), .owrite_en(owrite_en),
    .obusy(obusy), .odone(odone)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read source RAM: data one cycle after the address.
  always @(posedge clk) irdata <= in_ram[ord_addr];

  // Write/request/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (owrite_en === 1'b1) begin
      out_ram[owr_addr] = owdata;
      wr_log_a.push_back(int'(owr_addr));
      wr_log_d.push_back(owdata);
      wr_cnt = wr_cnt + 1;
    end
    if (ogen_otp === 1'b1) ogen_cnt = ogen_cnt + 1;
    if (odone === 1'b1) begin
      done_cnt   = done_cnt + 1;
      done_cyc   = cyc;
      done_waddr = int'(owr_addr);
    end
  end

  // Pad source: answers each request resp_lat cycles later.
  initial begin
    resp_ready = 1'b0;
    resp_val   = 64'h0;
    forever begin
      @(negedge clk); #1;
      if (ogen_otp === 1'b1) begin
        repeat (resp_lat) @(negedge clk);
        #1;
        resp_ready = 1'b1;
        resp_val   = pad_val;
        @(negedge clk); #1;
        resp_ready = 1'b0;
      end
    end
  end

  function automatic logic [3:0] model_nib(input logic [63:0] pad, input int j);
    logic [63:0] t;
    t = pad >> (60 - 4 * j);
    return t[3:0];
  endfunction

  function automatic int count_bad(input logic [63:0] pad);
    int bad = 0;
    for (int a = 0; a < N; a++)
      if (out_ram[a] !== (in_ram[a] ^ model_nib(pad, a % 16))) bad++;
    return bad;
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 5000) begin tick(); n++; end
    n_total++;
    if (done_cnt == d0) $display("FAIL done_timeout: odone count %0d required %0d", done_cnt, d0 + 1);
    else n_pass++;
  endtask

  task automatic run_block(input int lat, input logic [63:0] pad, output int start_cyc);
    int d0;
    resp_lat = lat; pad_val = pad; d0 = done_cnt;
    tick();
    start = 1'b1; start_cyc = cyc;
    tick();
    start = 1'b0;
    wait_done(d0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; inj_ready = 1'b0; inj_val = 64'h0;
    pad_val = 64'h0; resp_lat = 1;
    repeat (3) tick();
    n_total++;
    if ({ogen_otp, odone, obusy, owrite_en} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b required 0000", {ogen_otp, odone, obusy, owrite_en});
    else n_pass++;
    n_total++;
    if (ord_addr !== 10'd0 || owr_addr !== 10'd0 || owdata !== 4'h0)
      $display("FAIL reset_data: got %0h/%0h/%0h required 0/0/0", ord_addr, owr_addr, owdata);
    else n_pass++;
    rst = 1'b0;
    repeat (2) tick();
    n_total++;
    if (obusy !== 1'b0) $display("FAIL idle_busy: got %b required 0", obusy);
    else n_pass++;
  endtask

  task automatic test_basic();
    int base, s;
    for (int a = 0; a < N; a++) in_ram[a] = 4'hF;
    base = wr_cnt;
    run_block(2, 64'h0123456789ABCDEF, s);
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (wr_log_a[base + i] != i || wr_log_d[base + i] !== 4'(15 - i))
        $display("FAIL basic_nib%0d: got addr %0d data %0h required addr %0d data %0h",
                 i, wr_log_a[base + i], wr_log_d[base + i], i, 4'(15 - i));
      else n_pass++;
    end
  endtask

  task automatic test_full_block();
    int g0, w0, d0, s, bad;
    logic [63:0] p;
    p = 64'hA5C31E0F7B29D468;
    for (int a = 0; a < N; a++) in_ram[a] = 4'(a ^ (a >> 4) ^ (a >> 8));
    g0 = ogen_cnt; w0 = wr_cnt; d0 = done_cnt;
    run_block(3, p, s);
    repeat (3) tick();
    n_total++;
    if (ogen_cnt - g0 != 64) $display("FAIL full_req: got %0d required 64", ogen_cnt - g0);
    else n_pass++;
    n_total++;
    if (wr_cnt - w0 != N) $display("FAIL full_writes: got %0d required %0d", wr_cnt - w0, N);
    else n_pass++;
    n_total++;
    if (done_cnt - d0 != 1) $display("FAIL full_done: got %0d required 1", done_cnt - d0);
    else n_pass++;
    n_total++;
    if (done_cyc - s != 1281) $display("FAIL full_latency: got %0d required 1281", done_cyc - s);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < N; k++) if (wr_log_a[w0 + k] != k) bad++;
    n_total++;
    if (bad != 0) $display("FAIL full_order: got %0d misordered required 0", bad);
    else n_pass++;
    bad = count_bad(p);
    n_total++;
    if (bad != 0) $display("FAIL full_data: got %0d bad nibbles required 0", bad);
    else n_pass++;
    n_total++;
    if (done_waddr != N - 1) $display("FAIL done_waddr: got %0d required %0d", done_waddr, N - 1);
    else n_pass++;
    n_total++;
    if (ord_addr !== 10'd1023 || obusy !== 1'b0 || owrite_en !== 1'b0)
      $display("FAIL idle_hold: got addr %0d busy %b we %b required 1023 0 0", ord_addr, obusy, owrite_en);
    else n_pass++;
  endtask

  task automatic test_ignore();
    int g0, w0, d0, n, bad;
    logic [63:0] p;
    p = 64'h3C5A96F00FE1B287;
    for (int a = 0; a < N; a++) in_ram[a] = 4'(a * 7 + 3);
    resp_lat = 5; pad_val = p;
    g0 = ogen_cnt; w0 = wr_cnt; d0 = done_cnt;
    inj_val = 64'hDEADBEEFDEADBEEF; inj_ready = 1'b1;   // in IDLE
    tick(); inj_ready = 1'b0;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    n = 0;
    while (ogen_otp !== 1'b1 && n < 50) begin tick(); n++; end
    tick(); start = 1'b1;                                // in WAIT
    tick(); start = 1'b0;
    n_total++;
    if (obusy !== 1'b1) $display("FAIL wait_busy: got %b required 1", obusy);
    else n_pass++;
    n = 0;
    while (owrite_en !== 1'b1 && n < 50) begin tick(); n++; end
    inj_ready = 1'b1;                                    // in XOR
    tick(); inj_ready = 1'b0;
    wait_done(d0);
    repeat (3) tick();
    n_total++;
    if (ogen_cnt - g0 != 64) $display("FAIL ign_req: got %0d required 64", ogen_cnt - g0);
    else n_pass++;
    n_total++;
    if (wr_cnt - w0 != N) $display("FAIL ign_writes: got %0d required %0d", wr_cnt - w0, N);
    else n_pass++;
    bad = count_bad(p);
    n_total++;
    if (bad != 0) $display("FAIL ign_data: got %0d bad nibbles required 0", bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n, w0, g0, s, bad;
    logic [63:0] p;
    p = 64'h0F1E2D3C4B5A6978;
    for (int a = 0; a < N; a++) in_ram[a] = 4'(a >> 2);
    resp_lat = 1; pad_val = p;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    n = 0;
    while (ord_addr !== 10'd500 && n < 2000) begin tick(); n++; end
    n_total++;
    if (ord_addr !== 10'd500) $display("FAIL mid_reach: got %0d required 500", ord_addr);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if ({ogen_otp, odone, obusy, owrite_en} !== 4'b0000 || ord_addr !== 10'd0 ||
        owr_addr !== 10'd0 || owdata !== 4'h0)
      $display("FAIL mid_reset: got ctrl %b addr %0d/%0d data %0h required 0",
               {ogen_otp, odone, obusy, owrite_en}, ord_addr, owr_addr, owdata);
    else n_pass++;
    w0 = wr_cnt; g0 = ogen_cnt;
    repeat (2) tick();
    rst = 1'b0;
    repeat (40) tick();
    n_total++;
    if (wr_cnt != w0 || ogen_cnt != g0)
      $display("FAIL mid_quiet: got %0d writes %0d reqs required 0 0", wr_cnt - w0, ogen_cnt - g0);
    else n_pass++;
    run_block(1, p, s);
    n_total++;
    if (wr_log_a[w0] != 0) $display("FAIL restart_addr: got %0d required 0", wr_log_a[w0]);
    else n_pass++;
    bad = count_bad(p);
    n_total++;
    if (bad != 0) $display("FAIL restart_data: got %0d bad nibbles required 0", bad);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    int s, bad;
    for (int a = 0; a < N; a++) in_ram[a] = 4'($urandom_range(0, 15));
    run_block(2, 64'h0, s);
    bad = 0;
    for (int a = 0; a < N; a++) if (out_ram[a] !== in_ram[a]) bad++;
    n_total++;
    if (bad != 0) $display("FAIL pad_zero: got %0d bad nibbles required 0", bad);
    else n_pass++;
    run_block(2, 64'hFFFFFFFFFFFFFFFF, s);
    bad = 0;
    for (int a = 0; a < N; a++) if (out_ram[a] !== ~in_ram[a]) bad++;
    n_total++;
    if (bad != 0) $display("FAIL pad_ones: got %0d bad nibbles required 0", bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_block();
    test_ignore();
    test_reset_mid();
    test_passthrough();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
